// File: rtl/decoder_seq.sv
//==============================================================================
// Module   : decoder_seq
// Brief    : Registered one-hot decoder with valid/ready handshake and
//            auto-sequencing up/down scan mode.
// Revision : 1.0
//==============================================================================
`default_nettype none

module decoder_seq #(
    parameter  int SEL_W = 5,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] limit,
    input  logic             en,
    output logic [OUT_W-1:0] m,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [1:0] C_MODE_DIRECT  = 2'b00;
    localparam logic [1:0] C_MODE_SCAN_UP = 2'b01;
    localparam logic [1:0] C_MODE_SCAN_DN = 2'b10;

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_idx, w_idx_nxt;
    logic [SEL_W-1:0] r_limit, w_limit_nxt;
    logic             r_en, w_en_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_wrap, w_wrap_nxt;
    logic             w_in_fire;
    logic             w_out_fire;

    // m_valid comes straight from the state register, so in_valid never
    // reaches it combinationally; only in_ready looks at m_ready.
    assign m_valid    = (r_state != ST_IDLE);
    assign in_ready   = (r_state == ST_IDLE) | m_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = m_valid & m_ready;

    assign m    = r_en ? (OUT_W'(1) << r_idx) : '0;
    assign idx  = r_idx;
    assign wrap = r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_limit <= '0;
            r_en    <= 1'b0;
            r_dir   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_limit <= w_limit_nxt;
            r_en    <= w_en_nxt;
            r_dir   <= w_dir_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_limit_nxt = r_limit;
        w_en_nxt    = r_en;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = r_wrap;

        if (w_in_fire) begin
            // A new command takes priority over advancing the current beat.
            w_wrap_nxt = 1'b0;
            case (mode)
                C_MODE_DIRECT: begin
                    w_state_nxt = ST_DIRECT;
                    w_idx_nxt   = sel;
                    w_en_nxt    = en;
                end
                C_MODE_SCAN_UP, C_MODE_SCAN_DN: begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = sel;
                    w_en_nxt    = en;
                    w_limit_nxt = limit;
                    w_dir_nxt   = mode[1];
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (w_out_fire) begin
            if (r_state == ST_DIRECT) begin
                w_state_nxt = ST_IDLE;
            end else if (r_state == ST_SCAN) begin
                if (r_dir) begin
                    if (r_idx == '0) begin
                        w_idx_nxt  = r_limit;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx - SEL_W'(1);
                        w_wrap_nxt = 1'b0;
                    end
                end else begin
                    // Start above limit: natural rollover at all-ones also wraps.
                    if (r_idx == r_limit) begin
                        w_idx_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + SEL_W'(1);
                        w_wrap_nxt = (r_idx == {SEL_W{1'b1}});
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
